// File: rtl/bl_order_gen_hs.sv
// Baseline order generator: emits every antenna pair of a correlator set with its accumulation bank.
// Optional BL_ORDER_GEN_IDX_EN adds a registered bl_idx output counting baselines within a set.
`timescale 1ns/1ps
module bl_order_gen_hs #(
   parameter  int N_ANTS   = 16,
   parameter  int N_BUFS   = 2,
   localparam int ANT_BITS = $clog2(N_ANTS),
   localparam int BUF_BITS = (N_BUFS > 2) ? $clog2(N_BUFS) : 1
`ifdef BL_ORDER_GEN_IDX_EN
   ,
   localparam int N_BL     = N_ANTS * (N_ANTS / 2 + 1),
   localparam int IDX_BITS = $clog2(N_BL)
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [ANT_BITS-1:0] ant_a,
   output logic [ANT_BITS-1:0] ant_b,
   output logic [BUF_BITS-1:0] buf_sel,
   output logic                last_triangle,
   output logic                first_bl,
   output logic                last_bl
`ifdef BL_ORDER_GEN_IDX_EN
   ,
   output logic [IDX_BITS-1:0] bl_idx
`endif
);

   localparam logic [ANT_BITS-1:0] A_START   = ANT_BITS'(N_ANTS / 2);
   localparam logic [ANT_BITS-1:0] OFF_START = ANT_BITS'(N_ANTS / 2 + 1);
   localparam logic [ANT_BITS-1:0] A_LAST    = ANT_BITS'(N_ANTS - 1);
   localparam logic [ANT_BITS-1:0] ANT_ONE   = ANT_BITS'(1);
   localparam logic [BUF_BITS-1:0] BANK_LAST = BUF_BITS'(N_BUFS - 1);
   localparam logic [BUF_BITS-1:0] BANK_ONE  = BUF_BITS'(1);

   logic [ANT_BITS-1:0] a;
   logic [ANT_BITS-1:0] b;
   logic [ANT_BITS-1:0] offset;
   logic [BUF_BITS-1:0] bank;

   logic                load;
   logic                hold_free;
   logic                diag;
   logic                set_end;
   logic                lower;
   logic                is_first;
   logic [BUF_BITS-1:0] bank_prev;
   logic [BUF_BITS-1:0] bank_next;

   always_comb begin
      hold_free = ~out_valid | out_ready;
      load      = en & hold_free;
      diag      = (a == b);
      set_end   = diag & (a == A_LAST);
      lower     = (a > b);
      is_first  = (a == A_START) & (b == '0);
      // bank counts need not be a power of two, so both wraps are explicit
      bank_prev = (bank == '0)       ? BANK_LAST : bank - BANK_ONE;
      bank_next = (bank == BANK_LAST) ? '0       : bank + BANK_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a             <= A_START;
         b             <= '0;
         offset        <= OFF_START;
         bank          <= '0;
         out_valid     <= 1'b0;
         ant_a         <= '0;
         ant_b         <= '0;
         buf_sel       <= '0;
         last_triangle <= 1'b0;
         first_bl      <= 1'b0;
         last_bl       <= 1'b0;
      end else if (load) begin
         out_valid     <= 1'b1;
         ant_a         <= a;
         ant_b         <= b;
         buf_sel       <= lower ? bank_prev : bank;
         last_triangle <= lower;
         first_bl      <= is_first;
         last_bl       <= set_end;
         if (diag) begin
            b      <= b + ANT_ONE;
            a      <= offset;
            offset <= offset + ANT_ONE;
         end else begin
            a <= a + ANT_ONE;
         end
         if (set_end) begin
            bank <= bank_next;
         end
      end else if (hold_free) begin
         out_valid <= 1'b0;
      end
   end

`ifdef BL_ORDER_GEN_IDX_EN
   localparam logic [IDX_BITS-1:0] IDX_ONE = IDX_BITS'(1);

   logic [IDX_BITS-1:0] idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         bl_idx <= '0;
      end else if (load) begin
         bl_idx <= idx;
         idx    <= set_end ? '0 : idx + IDX_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_bl_order_gen_hs.sv
// Scoreboard bench for bl_order_gen_hs: a 4-antenna/3-bank instance driven by directed phases
// and a free-running 16-antenna instance; monitors pop expected baselines on each handshake.
`timescale 1ns/1ps
module tb_bl_order_gen_hs;

   typedef struct {
      int a;
      int b;
      int bs;
      int lt;
      int fb;
      int lb;
      int idx;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4-antenna, 3-bank instance
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       out_ready = 1'b1;
   logic       out_valid;
   logic [1:0] ant_a;
   logic [1:0] ant_b;
   logic [1:0] buf_sel;
   logic       last_triangle;
   logic       first_bl;
   logic       last_bl;
`ifdef BL_ORDER_GEN_IDX_EN
   logic [3:0] bl_idx;
`endif

   bl_order_gen_hs #(.N_ANTS(4), .N_BUFS(3)) dut (
      .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
      .out_valid(out_valid), .ant_a(ant_a), .ant_b(ant_b), .buf_sel(buf_sel),
      .last_triangle(last_triangle), .first_bl(first_bl), .last_bl(last_bl)
`ifdef BL_ORDER_GEN_IDX_EN
      , .bl_idx(bl_idx)
`endif
   );

   // 16-antenna, 2-bank instance
   logic       rst16 = 1'b1;
   logic       en16 = 1'b0;
   logic       ready16 = 1'b1;
   logic       valid16;
   logic [3:0] a16;
   logic [3:0] b16;
   logic [0:0] bs16;
   logic       lt16;
   logic       fb16;
   logic       lb16;
`ifdef BL_ORDER_GEN_IDX_EN
   logic [7:0] idx16;
`endif

   bl_order_gen_hs #(.N_ANTS(16), .N_BUFS(2)) dut16 (
      .clk(clk), .rst(rst16), .en(en16), .out_ready(ready16),
      .out_valid(valid16), .ant_a(a16), .ant_b(b16), .buf_sel(bs16),
      .last_triangle(lt16), .first_bl(fb16), .last_bl(lb16)
`ifdef BL_ORDER_GEN_IDX_EN
      , .bl_idx(idx16)
`endif
   );

   // Hand-derived baseline order of one 4-antenna set
   int tbl_a  [12] = '{2, 3, 0, 3, 0, 1, 0, 1, 2, 1, 2, 3};
   int tbl_b  [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
   int tbl_lt [12] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

   exp_t q[$];
   exp_t q16[$];
   int   exp_set = 0;
   int   exp_idx = 0;

   task automatic push4(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.a   = tbl_a[exp_idx];
         e.b   = tbl_b[exp_idx];
         e.lt  = tbl_lt[exp_idx];
         e.bs  = (e.lt != 0) ? (exp_set + 2) % 3 : exp_set % 3;
         e.fb  = (exp_idx == 0) ? 1 : 0;
         e.lb  = (exp_idx == 11) ? 1 : 0;
         e.idx = exp_idx;
         q.push_back(e);
         exp_idx++;
         if (exp_idx == 12) begin
            exp_idx = 0;
            exp_set++;
         end
      end
   endtask

   // Column b of a 16-antenna set visits a = b+8 .. b+16 (mod 16), 9 baselines per column
   task automatic push16(input int n);
      exp_t e;
      int j, s, col, kk;
      for (int k = 0; k < n; k++) begin
         j     = k % 144;
         s     = k / 144;
         col   = j / 9;
         kk    = j % 9;
         e.a   = (col + 8 + kk) % 16;
         e.b   = col;
         e.lt  = (e.a > e.b) ? 1 : 0;
         e.bs  = (e.lt != 0) ? 1 - (s % 2) : s % 2;
         e.fb  = (j == 0) ? 1 : 0;
         e.lb  = (j == 143) ? 1 : 0;
         e.idx = j;
         q16.push_back(e);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor for the 4-antenna instance: compare while presented, pop on acceptance
   always @(negedge clk) begin
      exp_t e;
      logic mis;
      if (out_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL bl4_extra got a=%0d b=%0d want no baseline", ant_a, ant_b);
         end else begin
            e   = q[0];
            mis = (ant_a !== e.a[1:0]) || (ant_b !== e.b[1:0]) || (buf_sel !== e.bs[1:0]) ||
                  (last_triangle !== e.lt[0]) || (first_bl !== e.fb[0]) || (last_bl !== e.lb[0]);
`ifdef BL_ORDER_GEN_IDX_EN
            mis = mis || (bl_idx !== e.idx[3:0]);
`endif
            if (mis) begin
               errors++;
               $display("FAIL bl4 got a=%0d b=%0d bs=%0d lt=%0b fb=%0b lb=%0b want a=%0d b=%0d bs=%0d lt=%0d fb=%0d lb=%0d idx=%0d",
                        ant_a, ant_b, buf_sel, last_triangle, first_bl, last_bl,
                        e.a, e.b, e.bs, e.lt, e.fb, e.lb, e.idx);
            end
            if (out_ready === 1'b1) void'(q.pop_front());
         end
      end
   end

   // Monitor for the 16-antenna instance
   always @(negedge clk) begin
      exp_t e;
      logic mis;
      if (valid16 === 1'b1 && ready16 === 1'b1) begin
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL bl16_extra got a=%0d b=%0d want no baseline", a16, b16);
         end else begin
            e   = q16.pop_front();
            mis = (a16 !== e.a[3:0]) || (b16 !== e.b[3:0]) || (bs16 !== e.bs[0:0]) ||
                  (lt16 !== e.lt[0]) || (fb16 !== e.fb[0]) || (lb16 !== e.lb[0]);
`ifdef BL_ORDER_GEN_IDX_EN
            mis = mis || (idx16 !== e.idx[7:0]);
`endif
            if (mis) begin
               errors++;
               $display("FAIL bl16 got a=%0d b=%0d bs=%0d lt=%0b fb=%0b lb=%0b want a=%0d b=%0d bs=%0d lt=%0d fb=%0d lb=%0d idx=%0d",
                        a16, b16, bs16, lt16, fb16, lb16, e.a, e.b, e.bs, e.lt, e.fb, e.lb, e.idx);
            end
         end
      end
   end

   initial begin
      int budget;

      cyc(3);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ant_a", 32'(ant_a), 0);
      chk("rst_ant_b", 32'(ant_b), 0);
      chk("rst_buf_sel", 32'(buf_sel), 0);
      chk("rst_last_tri", 32'(last_triangle), 0);
      chk("rst_first", 32'(first_bl), 0);
      chk("rst_last", 32'(last_bl), 0);
      chk("rst_valid16", 32'(valid16), 0);

      rst   = 1'b0;
      rst16 = 1'b0;
      en16  = 1'b1;
      push16(300);

      // 40 back-to-back baselines: three full sets plus four, banks 0,1,2,0
      push4(40);
      en = 1'b1;
      cyc(40);
      en = 1'b0;
      cyc(2);
      chk("drain_stream", 32'(q.size()), 0);

      // Downstream stall for 5 cycles mid-set
      push4(9);
      en = 1'b1;
      cyc(3);
      out_ready = 1'b0;
      cyc(5);
      chk("stall_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      cyc(6);
      en = 1'b0;
      cyc(2);
      chk("drain_stall", 32'(q.size()), 0);

      // Enable toggled 1,0,1
      push4(4);
      en = 1'b1;
      cyc(2);
      chk("en_hi_valid", 32'(out_valid), 1);
      en = 1'b0;
      cyc(1);
      chk("en_lo_valid", 32'(out_valid), 0);
      en = 1'b1;
      cyc(2);
      chk("en_hi2_valid", 32'(out_valid), 1);
      en = 1'b0;
      cyc(2);
      chk("drain_en", 32'(q.size()), 0);

      // Reset while baseline 7 of the set (bank 1) is presented
      push4(2);
      en = 1'b1;
      cyc(2);
      chk("pre_rst_ant_a", 32'(ant_a), 0);
      chk("pre_rst_ant_b", 32'(ant_b), 2);
      rst = 1'b1;
      cyc(1);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_buf_sel", 32'(buf_sel), 0);
      chk("mid_rst_first", 32'(first_bl), 0);
      chk("mid_rst_queue", 32'(q.size()), 0);
      rst     = 1'b0;
      exp_set = 0;
      exp_idx = 0;
      push4(12);
      cyc(12);
      en = 1'b0;
      cyc(2);
      chk("drain_rst", 32'(q.size()), 0);

      budget = 0;
      while (q16.size() != 0 && budget < 2000) begin
         cyc(1);
         budget++;
      end
      chk("drain_bl16", 32'(q16.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bl_order_gen_hs.md
BL_ORDER_GEN_HS -- requirements
Module: bl_order_gen_hs

Interface
REQ-001 SHALL have parameter N_ANTS, default 16, number of antennas; power of two, 4 to 256.
REQ-002 SHALL have parameter N_BUFS, default 2, number of accumulation buffer banks; 2 to 16.
REQ-003 SHALL derive ANT_BITS = ceil(log2(N_ANTS)), BUF_BITS = max(1, ceil(log2(N_BUFS))), N_BL = N_ANTS*(N_ANTS/2+1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, generator enable; when low, no new baseline is produced.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts the presented baseline.
REQ-008 SHALL have port out_valid, output, 1, output register holds a valid baseline.
REQ-009 SHALL have port ant_a, output, ANT_BITS, first antenna of the baseline.
REQ-010 SHALL have port ant_b, output, ANT_BITS, second antenna of the baseline.
REQ-011 SHALL have port buf_sel, output, BUF_BITS, buffer bank the baseline accumulates into.
REQ-012 SHALL have port last_triangle, output, 1, high when ant_a > ant_b.
REQ-013 SHALL have port first_bl, output, 1, high on the first baseline of a set (ant_a=N_ANTS/2, ant_b=0).
REQ-014 SHALL have port last_bl, output, 1, high on the last baseline of a set (ant_a=ant_b=N_ANTS-1).

Function
REQ-015 SHALL keep internal state a, b, offset (ANT_BITS each) and bank (BUF_BITS).
REQ-016 SHALL define load = en & (~out_valid | out_ready); on load, the output register takes {a, b, derived flags} and the state advances.
REQ-017 SHALL, when (~out_valid | out_ready) & ~en, clear out_valid; when out_valid & ~out_ready, hold all outputs stable.
REQ-018 SHALL advance as follows: if a==b, then b <= b+1, a <= offset and offset <= offset+1, all mod N_ANTS; else a <= a+1 mod N_ANTS.
REQ-019 SHALL, on the advance that consumes a==b==N_ANTS-1, set bank <= bank+1, wrapping N_BUFS-1 to 0; wrap SHALL be explicit for non-power-of-two N_BUFS.
REQ-020 SHALL, at load, compute buf_sel = bank if a<=b, else (bank-1) mod N_BUFS; last_triangle SHALL be (a>b).
REQ-021 SHALL produce exactly N_BL baselines per set, then continue seamlessly with the next set with no idle cycle.
REQ-022 SHALL have latency of one cycle: a baseline loaded at edge k is visible on the outputs after edge k.
REQ-023 SHALL sustain one baseline per cycle with en=1 and out_ready=1.

Reset
REQ-024 SHALL, on rst, set a=N_ANTS/2, b=0, offset=N_ANTS/2+1 mod N_ANTS, bank=0, out_valid=0, ant_a=0, ant_b=0, buf_sel=0, and all flags=0.
REQ-025 SHALL give rst priority over en and out_ready; rst mid-set SHALL discard the held baseline and restart at first_bl.

Configuration
REQ-026 SHALL, with macro BL_ORDER_GEN_IDX_EN defined, add output bl_idx of width ceil(log2(N_BL)), registered with the other outputs: 0 at first_bl, +1 per loaded baseline, N_BL-1 at last_bl, reset to 0.
REQ-027 SHALL, without BL_ORDER_GEN_IDX_EN, have no bl_idx port and no index counter; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: N_ANTS=4, rst then en=1, out_ready=1 -> (a,b) = (2,0),(3,0),(0,0),(3,1),(0,1),(1,1),(0,2),(1,2),(2,2),(1,3),(2,3),(3,3); first_bl on the 1st, last_bl on the 12th, last_triangle on the 1st, 2nd and 4th.
REQ-029 SHALL cover: N_ANTS=4, N_BUFS=3, 40 accepted cycles -> bank sequence 0,1,2,0 at set boundaries; buf_sel = previous bank on last_triangle baselines (e.g. 2 at set start with bank 0).
REQ-030 SHALL cover: out_ready low for 5 cycles mid-set -> outputs frozen, no baseline skipped or duplicated once out_ready is high.
REQ-031 SHALL cover: en toggled 1,0,1 with out_ready=1 -> out_valid 1,0,1, and the sequence resumes at the next baseline.
REQ-032 SHALL cover: rst asserted at baseline 7 -> out_valid=0 the next cycle, and the first baseline after release is (2,0) with first_bl=1 and bank 0.
REQ-033 SHALL cover: BL_ORDER_GEN_IDX_EN defined, N_ANTS=16 -> bl_idx runs 0..143 and wraps to 0 coincident with first_bl.
